// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants used by the fetch stage.
package mips_pkg;

    localparam int PC_W = 32;

    localparam logic [PC_W-1:0] MIPS_NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory req/ready handshake between the fetch stage (master) and imem (slave).
interface if_fetch_unit_if;
    import mips_pkg::*;

    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ready;
    logic [PC_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/if_fetch_unit.sv
// MIPS IF stage: PC register, next-PC select, imem handshake and NOP bubble insertion.
// Define IF_FETCH_PERF_CNT_EN to add the stall_cycles / redirect_drops counters.
module if_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            freeze,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    if_fetch_unit_if.master imem,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] inst,
    output logic            inst_valid
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cycles,
    output logic [15:0]     redirect_drops
`endif
);

    localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

    fetch_state_t    state, state_nxt;
    logic [PC_W-1:0] pc_reg, pc_nxt;
    logic [PC_W-1:0] stale_addr, stale_nxt;
    logic [PC_W-1:0] hold_inst, hold_inst_nxt;
    logic [PC_W-1:0] hold_pc, hold_pc_nxt;
    logic [PC_W-1:0] pc_inc;
    logic            req;
    logic [PC_W-1:0] addr;

    assign pc_inc         = pc_reg + STEP;
    assign imem.imem_req  = req;
    assign imem.imem_addr = addr;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= S_FETCH;
            pc_reg     <= RESET_PC;
            stale_addr <= RESET_PC;
            hold_inst  <= '0;
            hold_pc    <= '0;
        end else begin
            state      <= state_nxt;
            pc_reg     <= pc_nxt;
            stale_addr <= stale_nxt;
            hold_inst  <= hold_inst_nxt;
            hold_pc    <= hold_pc_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc_reg;
        stale_nxt     = stale_addr;
        hold_inst_nxt = hold_inst;
        hold_pc_nxt   = hold_pc;
        req           = 1'b1;
        addr          = pc_reg;
        inst          = MIPS_NOP;
        pc            = '0;
        inst_valid    = 1'b0;

        case (state)
            S_FETCH: begin
                if (imem.imem_ready) begin
                    inst       = imem.imem_rdata;
                    pc         = pc_inc;
                    inst_valid = 1'b1;
                end
                if (branch_taken) begin
                    pc_nxt = branch_target;
                    // A request already on the bus must complete before the new address goes out.
                    if (!imem.imem_ready) begin
                        stale_nxt = pc_reg;
                        state_nxt = S_DROP;
                    end
                end else if (imem.imem_ready) begin
                    pc_nxt = pc_inc;
                    if (freeze) begin
                        hold_inst_nxt = imem.imem_rdata;
                        hold_pc_nxt   = pc_inc;
                        state_nxt     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                req        = 1'b0;
                inst       = hold_inst;
                pc         = hold_pc;
                inst_valid = 1'b1;
                if (branch_taken) begin
                    pc_nxt    = branch_target;
                    state_nxt = S_FETCH;
                end else if (!freeze) begin
                    state_nxt = S_FETCH;
                end
            end
            S_DROP: begin
                addr = stale_addr;
                if (branch_taken) begin
                    pc_nxt = branch_target;
                end
                if (imem.imem_ready) begin
                    state_nxt = S_FETCH;
                end
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase

        // Any redirect makes this cycle's output a bubble, whatever the state produced.
        if (branch_taken) begin
            inst       = MIPS_NOP;
            pc         = '0;
            inst_valid = 1'b0;
        end
    end

`ifdef IF_FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            stall_cycles   <= '0;
            redirect_drops <= '0;
        end else begin
            if (req && !imem.imem_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if ((state == S_FETCH) && (state_nxt == S_DROP)) begin
                redirect_drops <= redirect_drops + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: transaction-level model checked every cycle plus directed literals.
module tb_if_fetch_unit;
    import mips_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PATTERN  = 32'hA5A5_0000;

    logic        clk           = 1'b0;
    logic        rst_b         = 1'b0;
    logic        freeze        = 1'b0;
    logic        branch_taken  = 1'b0;
    logic        ready         = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [15:0] redirect_drops;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    if_fetch_unit_if bus ();

    // Memory returns a word derived from its address so every fetch is distinguishable.
    assign bus.imem_ready = ready;
    assign bus.imem_rdata = bus.imem_addr ^ PATTERN;

    if_fetch_unit #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (4)
    ) dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .freeze        (freeze),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem          (bus),
        .pc            (pc),
        .inst          (inst),
        .inst_valid    (inst_valid)
`ifdef IF_FETCH_PERF_CNT_EN
        ,
        .stall_cycles  (stall_cycles),
        .redirect_drops(redirect_drops)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_cycle(input string name, input logic e_req, input logic [31:0] e_addr,
                               input logic e_valid, input logic [31:0] e_inst, input logic [31:0] e_pc);
        check_bit({name, ".req"}, bus.imem_req, e_req);
        if (e_req) check_output({name, ".addr"}, bus.imem_addr, e_addr);
        check_bit({name, ".valid"}, inst_valid, e_valid);
        check_output({name, ".inst"}, inst, e_inst);
        if (e_valid) check_output({name, ".pc"}, pc, e_pc);
    endtask

    task automatic apply_stimulus(input logic rdy, input logic frz, input logic br, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        ready         = rdy;
        freeze        = frz;
        branch_taken  = br;
        branch_target = tgt;
        #1;
    endtask

    // Model state in fetch-transaction terms: what address is wanted next, whether a word
    // is parked for a frozen decoder, and whether an abandoned request is still on the bus.
    logic [31:0] m_next_addr;
    logic        m_holding;
    logic [31:0] m_held_word;
    logic [31:0] m_held_pc;
    logic        m_dropping;
    logic [31:0] m_drop_addr;
    logic [31:0] m_stall;
    logic [15:0] m_drops;

    always @(negedge clk) begin
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        if (!rst_b) begin
            m_next_addr = RESET_PC;
            m_holding   = 1'b0;
            m_held_word = 32'h0;
            m_held_pc   = 32'h0;
            m_dropping  = 1'b0;
            m_drop_addr = 32'h0;
            m_stall     = 32'h0;
            m_drops     = 16'h0;
            check_cycle("model_reset", 1'b1, RESET_PC, 1'b0, 32'h0, 32'h0);
`ifdef IF_FETCH_PERF_CNT_EN
            check_output("model_reset.stall_cycles", stall_cycles, 32'h0);
            check_output("model_reset.redirect_drops", {16'h0, redirect_drops}, 32'h0);
`endif
        end else begin
            e_req   = 1'b1;
            e_addr  = m_next_addr;
            e_valid = 1'b0;
            e_inst  = 32'h0;
            e_pc    = 32'h0;
            if (m_dropping) begin
                e_addr = m_drop_addr;
            end else if (m_holding) begin
                e_req   = 1'b0;
                e_valid = 1'b1;
                e_inst  = m_held_word;
                e_pc    = m_held_pc;
            end else if (ready) begin
                e_valid = 1'b1;
                e_inst  = m_next_addr ^ PATTERN;
                e_pc    = m_next_addr + 32'd4;
            end
            if (branch_taken) begin
                e_valid = 1'b0;
                e_inst  = 32'h0;
                e_pc    = 32'h0;
            end
            check_cycle("model", e_req, e_addr, e_valid, e_inst, e_pc);
`ifdef IF_FETCH_PERF_CNT_EN
            check_output("model.stall_cycles", stall_cycles, m_stall);
            check_output("model.redirect_drops", {16'h0, redirect_drops}, {16'h0, m_drops});
            if (e_req && !ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
            if (branch_taken && !m_dropping && !m_holding && !ready) m_drops = m_drops + 16'd1;
`endif
            if (branch_taken) begin
                if (!m_dropping && !m_holding && !ready) begin
                    m_dropping  = 1'b1;
                    m_drop_addr = m_next_addr;
                end else if (m_dropping && ready) begin
                    m_dropping = 1'b0;
                end
                m_holding   = 1'b0;
                m_next_addr = branch_target;
            end else if (m_dropping) begin
                if (ready) m_dropping = 1'b0;
            end else if (m_holding) begin
                if (!freeze) m_holding = 1'b0;
            end else if (ready) begin
                if (freeze) begin
                    m_holding   = 1'b1;
                    m_held_word = m_next_addr ^ PATTERN;
                    m_held_pc   = m_next_addr + 32'd4;
                end
                m_next_addr = m_next_addr + 32'd4;
            end
        end
    end

    initial begin
        $display("[TB] start");
        repeat (2) @(posedge clk);
        #1;
        check_cycle("reset", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        rst_b = 1'b1;

        // Zero-wait stream
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check_cycle("zw0", 1'b1, 32'h0, 1'b1, 32'hA5A5_0000, 32'h4);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check_cycle("zw1", 1'b1, 32'h4, 1'b1, 32'hA5A5_0004, 32'h8);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check_cycle("zw2", 1'b1, 32'h8, 1'b1, 32'hA5A5_0008, 32'hC);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);

        // Wait states at 0x10
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
            check_cycle("wait", 1'b1, 32'h10, 1'b0, 32'h0, 32'h0);
        end
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check_cycle("wait_done", 1'b1, 32'h10, 1'b1, 32'hA5A5_0010, 32'h14);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);

        // Freeze while 0x20 returns
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
        check_cycle("frz_fetch", 1'b1, 32'h20, 1'b1, 32'hA5A5_0020, 32'h24);
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
        check_cycle("frz_hold", 1'b0, 32'h0, 1'b1, 32'hA5A5_0020, 32'h24);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check_cycle("frz_release", 1'b0, 32'h0, 1'b1, 32'hA5A5_0020, 32'h24);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check_cycle("frz_next", 1'b1, 32'h24, 1'b1, 32'hA5A5_0024, 32'h28);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);

        // Redirect while 0x30 is waiting
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h100);
        check_cycle("rd_req", 1'b1, 32'h30, 1'b0, 32'h0, 32'h0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
        check_cycle("rd_drop", 1'b1, 32'h30, 1'b0, 32'h0, 32'h0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check_cycle("rd_discard", 1'b1, 32'h30, 1'b0, 32'h0, 32'h0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check_cycle("rd_target", 1'b1, 32'h100, 1'b1, 32'hA5A5_0100, 32'h104);

        // Redirect beats freeze in hold
        apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
        apply_stimulus(1'b1, 1'b1, 1'b1, 32'h200);
        check_cycle("rvf_bubble", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check_cycle("rvf_target", 1'b1, 32'h200, 1'b1, 32'hA5A5_0200, 32'h204);

        // Reset while dropping
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h300);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
        check_cycle("rst_drop", 1'b1, 32'h204, 1'b0, 32'h0, 32'h0);
        #1;
        rst_b = 1'b0;
        #1;
        check_cycle("rst_async", 1'b1, RESET_PC, 1'b0, 32'h0, 32'h0);
`ifdef IF_FETCH_PERF_CNT_EN
        check_output("rst_async.stall_cycles", stall_cycles, 32'h0);
        check_output("rst_async.redirect_drops", {16'h0, redirect_drops}, 32'h0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;

        // PC wrap and unaligned target pass-through
        apply_stimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        check_cycle("wrap_redirect", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check_cycle("wrap_top", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h5A5A_FFFC, 32'h0);
        apply_stimulus(1'b1, 1'b0, 1'b1, 32'h42);
        check_cycle("wrap_zero", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check_cycle("unaligned", 1'b1, 32'h42, 1'b1, 32'hA5A5_0042, 32'h46);

        // Mixed tail exercising drop-then-redirect-again
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h500);
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h600);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        check_cycle("last_redirect", 1'b1, 32'h600, 1'b1, 32'hA5A5_0600, 32'h604);
        apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
